// File: rtl/bc_run_ctrl.sv
// Purpose : run-control for the basic computer; start/stop, auto-restart, PC breakpoint, HLT pause, single-step.
// Latency : all outputs registered; a control decision made on edge N is visible on cpu_en/cpu_clr/state after edge N.
// Backpressure: none; control pulses are sampled every cycle, and start/stop are ignored while a clear sequence runs.
// Ports   : clk/clr_n (async active-low); start/stop/resume/step pulses; halt_in, pc observed from the computer;
//           bp_en/bp_addr breakpoint; period auto-restart length (0 = off); cpu_en/cpu_clr drive the computer;
//           state (IDLE=0 CLEAR=1 RUN=2 PAUSE=3 STEP=4); bp_hit sticky breakpoint flag;
//           cyc_cnt enabled-cycle count, present only when BC_RUN_CYCLE_CNT_EN is defined (else tied to 0).
module bc_run_ctrl #(
  parameter int ADDR_W     = 12,
  parameter int PER_W      = 16,
  parameter int CLR_CYCLES = 1,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              start,
  input  logic              stop,
  input  logic              resume,
  input  logic              step,
  input  logic              halt_in,
  input  logic [ADDR_W-1:0] pc,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [PER_W-1:0]  period,
  output logic              cpu_en,
  output logic              cpu_clr,
  output logic [2:0]        state,
  output logic              bp_hit,
  output logic [CNT_W-1:0]  cyc_cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_STEP  = 3'd4;

  localparam int              CLR_W    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

  logic [2:0]       state_d;
  logic [CLR_W-1:0] clr_cnt, clr_cnt_d;
  logic [PER_W-1:0] per_cnt, per_cnt_d;
  logic             bp_mask, bp_mask_d;
  logic             bp_trip, bp_release;
  logic             cpu_en_d, cpu_clr_d, bp_hit_d;
  logic             pc_at_bp, restart_due;

  assign pc_at_bp    = (pc == bp_addr);
  // >= rather than == so that shrinking period below the current count restarts on the next cycle.
  assign restart_due = (period != '0) && (per_cnt >= (period - PER_W'(1)));

  // State register (plus internal counters and registered outputs).
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= S_IDLE;
      clr_cnt <= '0;
      per_cnt <= '0;
      bp_mask <= 1'b0;
      cpu_en  <= 1'b0;
      cpu_clr <= 1'b0;
      bp_hit  <= 1'b0;
    end else begin
      state   <= state_d;
      clr_cnt <= clr_cnt_d;
      per_cnt <= per_cnt_d;
      bp_mask <= bp_mask_d;
      cpu_en  <= cpu_en_d;
      cpu_clr <= cpu_clr_d;
      bp_hit  <= bp_hit_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state;
    bp_trip    = 1'b0;
    bp_release = 1'b0;
    case (state)
      S_IDLE: begin
        bp_release = start | stop;
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        if (clr_cnt == CLR_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        bp_release = start | stop;
        if (stop)                          state_d = S_IDLE;
        else if (start)                    state_d = S_CLEAR;
        else if (halt_in)                  state_d = S_PAUSE;
        else if (bp_en && pc_at_bp && !bp_mask) begin
          state_d = S_PAUSE;
          bp_trip = 1'b1;
        end
        else if (restart_due)              state_d = S_CLEAR;
      end
      S_PAUSE: begin
        bp_release = start | stop | resume;
        if (stop)        state_d = S_IDLE;
        else if (start)  state_d = S_CLEAR;
        else if (resume) state_d = S_RUN;
        else if (step)   state_d = S_STEP;
      end
      S_STEP:  state_d = S_PAUSE;
      default: state_d = S_IDLE;
    endcase

    clr_cnt_d = (state == S_CLEAR && state_d == S_CLEAR) ? clr_cnt + CLR_W'(1) : '0;

    // Counts RUN cycles only; saturates so it never wraps except through a restart.
    per_cnt_d = per_cnt;
    if (state_d == S_CLEAR)                 per_cnt_d = '0;
    else if (state == S_RUN && !(&per_cnt)) per_cnt_d = per_cnt + PER_W'(1);

    // Mask lets a resume step off the breakpoint address; it drops once pc moves away.
    bp_mask_d = bp_mask;
    if (!pc_at_bp)                                bp_mask_d = 1'b0;
    if (state == S_PAUSE && state_d == S_RUN)     bp_mask_d = pc_at_bp;
    if (state_d == S_IDLE || state_d == S_CLEAR)  bp_mask_d = 1'b0;
  end

  // Output logic: outputs are decoded from the next state so they register in step with it.
  always_comb begin
    cpu_en_d  = (state_d == S_RUN) || (state_d == S_STEP);
    cpu_clr_d = (state_d == S_CLEAR);
    bp_hit_d  = bp_hit;
    if (bp_trip)         bp_hit_d = 1'b1;
    else if (bp_release) bp_hit_d = 1'b0;
  end

`ifdef BC_RUN_CYCLE_CNT_EN
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                       cyc_cnt <= '0;
    else if (state_d == S_CLEAR)      cyc_cnt <= '0;
    else if (cpu_en && !(&cyc_cnt))   cyc_cnt <= cyc_cnt + CNT_W'(1);
  end
`else
  assign cyc_cnt = '0;
`endif

endmodule

// File: tb/tb_bc_run_ctrl.sv
module tb_bc_run_ctrl;
  logic        clk;
  logic        clr_n;
  logic        start, stop, resume, step, halt_in;
  logic [11:0] pc;
  logic        bp_en;
  logic [11:0] bp_addr;
  logic [15:0] period;
  logic        cpu_en, cpu_clr;
  logic [2:0]  state;
  logic        bp_hit;
  logic [31:0] cyc_cnt;

  int checks = 0;
  int errors = 0;

  bc_run_ctrl dut (
    .clk(clk), .clr_n(clr_n), .start(start), .stop(stop), .resume(resume),
    .step(step), .halt_in(halt_in), .pc(pc), .bp_en(bp_en), .bp_addr(bp_addr),
    .period(period), .cpu_en(cpu_en), .cpu_clr(cpu_clr), .state(state),
    .bp_hit(bp_hit), .cyc_cnt(cyc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cyc_exp(input int n);
`ifdef BC_RUN_CYCLE_CNT_EN
    return 32'(n);
`else
    return (n == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  int          clr_at[$];
  int          en_seg;
  int          en_first_seg;

  initial begin
    clr_n = 1'b1;
    start = 0; stop = 0; resume = 0; step = 0; halt_in = 0;
    pc = 12'h000; bp_en = 0; bp_addr = 12'h010; period = 16'd400;
    #1 clr_n = 1'b0;
    #2;
    chk("rst_state",   32'(state),   32'd0);
    chk("rst_cpu_en",  32'(cpu_en),  32'd0);
    chk("rst_cpu_clr", 32'(cpu_clr), 32'd0);
    chk("rst_bp_hit",  32'(bp_hit),  32'd0);
    chk("rst_cyc_cnt", cyc_cnt,      32'd0);
    @(negedge clk) clr_n = 1'b1;
    tick();
    chk("idle_state", 32'(state), 32'd0);

    // Free run with period=400: start sampled at cycle 0, clears at 1, 402, 803.
    start = 1;
    tick();
    start = 0;
    en_seg = 0;
    en_first_seg = -1;
    for (int c = 1; c <= 1000; c++) begin
      if (c == 1) begin
        chk("clr1_state",  32'(state),  32'd1);
        chk("clr1_cpu_en", 32'(cpu_en), 32'd0);
      end
      if (c == 2) begin
        chk("run2_state",   32'(state),   32'd2);
        chk("run2_cpu_en",  32'(cpu_en),  32'd1);
        chk("run2_cpu_clr", 32'(cpu_clr), 32'd0);
      end
      if (cpu_clr) begin
        if (clr_at.size() == 1) en_first_seg = en_seg;
        clr_at.push_back(c);
        en_seg = 0;
      end
      if (cpu_en) en_seg++;
      if (c < 1000) tick();
    end
    chk("per_pulses", 32'(clr_at.size()), 32'd3);
    chk("per_clr_a",  32'(clr_at.size() > 0 ? clr_at[0] : -1), 32'd1);
    chk("per_clr_b",  32'(clr_at.size() > 1 ? clr_at[1] : -1), 32'd402);
    chk("per_clr_c",  32'(clr_at.size() > 2 ? clr_at[2] : -1), 32'd803);
    chk("per_en_seg", 32'(en_first_seg), 32'd400);
    chk("per_cyc",    cyc_cnt, cyc_exp(196));

    period = 0;
    stop = 1;
    tick();
    stop = 0;
    chk("stop_state",  32'(state),  32'd0);
    chk("stop_cpu_en", 32'(cpu_en), 32'd0);

    // Breakpoint at 0x010.
    bp_en = 1;
    start = 1;
    tick();
    start = 0;
    chk("bp_clr_state", 32'(state), 32'd1);
    tick();
    chk("bp_run_state", 32'(state), 32'd2);
    pc = 12'h00E;
    tick();
    pc = 12'h00F;
    tick();
    chk("bp_pre_state", 32'(state), 32'd2);
    pc = 12'h010;
    tick();
    chk("bp_state",  32'(state),  32'd3);
    chk("bp_hit",    32'(bp_hit), 32'd1);
    chk("bp_cpu_en", 32'(cpu_en), 32'd0);
    chk("bp_cyc",    cyc_cnt,     cyc_exp(3));
    tick();
    tick();
    chk("bp_hold_state", 32'(state), 32'd3);
    resume = 1;
    tick();
    resume = 0;
    chk("res_state",  32'(state),  32'd2);
    chk("res_bp_hit", 32'(bp_hit), 32'd0);
    chk("res_cpu_en", 32'(cpu_en), 32'd1);
    tick();
    chk("res_masked", 32'(state), 32'd2);
    pc = 12'h011;
    tick();
    chk("res_moved", 32'(state), 32'd2);
    pc = 12'h010;
    tick();
    chk("bp2_state",  32'(state),  32'd3);
    chk("bp2_bp_hit", 32'(bp_hit), 32'd1);
    chk("bp2_cyc",    cyc_cnt,     cyc_exp(6));

    // Three single steps, four cycles apart.
    for (int k = 0; k < 3; k++) begin
      step = 1;
      tick();
      step = 0;
      chk("step_state",  32'(state),  32'd4);
      chk("step_cpu_en", 32'(cpu_en), 32'd1);
      tick();
      chk("step_back",   32'(state),  32'd3);
      chk("step_en_off", 32'(cpu_en), 32'd0);
      tick();
      tick();
    end
    chk("step_cyc",    cyc_cnt,     cyc_exp(9));
    chk("step_bp_hit", 32'(bp_hit), 32'd1);

    // Halt with stop and start together: stop wins.
    bp_en = 0;
    resume = 1;
    tick();
    resume = 0;
    chk("h_run_state", 32'(state), 32'd2);
    halt_in = 1; stop = 1; start = 1;
    tick();
    halt_in = 0; stop = 0; start = 0;
    chk("h_stop_state",  32'(state),  32'd0);
    chk("h_stop_cpu_en", 32'(cpu_en), 32'd0);
    start = 1;
    tick();
    start = 0;
    tick();
    halt_in = 1;
    tick();
    chk("halt_state",  32'(state),  32'd3);
    chk("halt_cpu_en", 32'(cpu_en), 32'd0);
    chk("halt_bp_hit", 32'(bp_hit), 32'd0);
    resume = 1;
    tick();
    resume = 0;
    chk("halt_res_state", 32'(state), 32'd2);
    tick();
    chk("halt_repause", 32'(state), 32'd3);
    halt_in = 0;

    // Period shrunk below running count restarts on the next cycle.
    start = 1;
    tick();
    start = 0;
    tick();
    for (int i = 0; i < 10; i++) tick();
    chk("shrink_run", 32'(state), 32'd2);
    period = 16'd5;
    tick();
    chk("shrink_clr", 32'(state), 32'd1);
    period = 0;
    stop = 1;
    tick();
    stop = 0;
    chk("clr_ign_stop", 32'(state), 32'd2);
    stop = 1;
    tick();
    stop = 0;
    chk("stop2_state", 32'(state), 32'd0);

    // Asynchronous reset during CLEAR and during RUN.
    start = 1;
    tick();
    start = 0;
    #2 clr_n = 1'b0;
    #1;
    chk("arst_clr_state",   32'(state),   32'd0);
    chk("arst_clr_cpu_clr", 32'(cpu_clr), 32'd0);
    @(negedge clk) clr_n = 1'b1;
    tick();
    chk("arst_clr_after", 32'(cpu_clr), 32'd0);
    start = 1;
    tick();
    start = 0;
    tick();
    chk("arst_pre_run", 32'(state), 32'd2);
    #2 clr_n = 1'b0;
    #1;
    chk("arst_run_state",  32'(state),  32'd0);
    chk("arst_run_cpu_en", 32'(cpu_en), 32'd0);
    chk("arst_run_cyc",    cyc_cnt,     32'd0);
    @(negedge clk) clr_n = 1'b1;
    tick();
    chk("arst_run_after_clr", 32'(cpu_clr), 32'd0);
    chk("arst_run_after_st",  32'(state),   32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
